// File: rtl/accum_operand_streamer.sv
// Streams a contiguous run of operands from a synchronous-read memory to the
// accumulator over valid/ready/last, hiding the read latency behind a 2-entry FIFO.
module accum_operand_streamer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              load;
    logic [ADDR_W-1:0] base_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  issued_reg;
    logic [LEN_W-1:0]  received_reg;
    logic              inflight_reg;

    logic [1:0]        count_reg;
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [DATA_W-1:0] fifo_data_reg [2];
    logic              fifo_last_reg [2];

    logic              push;
    logic              pop;
    logic [2:0]        occ_after_pop;

    assign push = inflight_reg;
    assign pop  = out_valid & out_ready;

    // Entries held or already requested, less the one leaving this cycle;
    // a new read is only safe if it still leaves room for its data.
    assign occ_after_pop = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

    assign mem_rd_en = (state_reg == RUN) && (issued_reg < len_reg) && (occ_after_pop < 3'd2);
    assign mem_addr  = base_reg + issued_reg[ADDR_W-1:0];

    assign out_valid = (count_reg != 2'd0);
    assign out_data  = fifo_data_reg[rd_ptr_reg];
    assign out_last  = out_valid & fifo_last_reg[rd_ptr_reg];

    assign busy = (state_reg == RUN);
    assign done = (state_reg == FINISH);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (length == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (pop && out_last) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            len_reg      <= '0;
            issued_reg   <= '0;
            received_reg <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= mem_rd_en;
            if (load) begin
                base_reg     <= base_addr;
                len_reg      <= length;
                issued_reg   <= '0;
                received_reg <= '0;
            end else begin
                if (mem_rd_en) begin
                    issued_reg <= issued_reg + 1'b1;
                end
                if (push) begin
                    received_reg <= received_reg + 1'b1;
                end
            end
        end
    end

    // The last flag is decided at write time so it travels with its operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_last_reg[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data_reg[wr_ptr_reg] <= mem_rd_data;
                fifo_last_reg[wr_ptr_reg] <= (received_reg == len_reg - 1'b1);
                wr_ptr_reg                <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
